// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin synchronisation, 11-bit frame deframing,
// scan-code-set-2 E0/F0 prefix resolution and held-key flags for the game.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYC = 2000,
    parameter int unsigned TO_W        = 11
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_code,
    output logic       o_extended,
    output logic       o_break,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_key_left,
    output logic       o_key_right,
    output logic       o_key_fire,
    output logic       o_key_start,
    output logic       o_key_r
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic            ps2_clk_m, ps2_clk_s, ps2_clk_d;
    logic            ps2_data_m, ps2_data_s;
    logic            fe;

    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [TO_W-1:0] to_cnt;
    logic            rx_rdy;
    logic [7:0]      rx_byte;

    logic            start_err, stop_fe, frame_good, to_expire, err_set;
    logic            ext_pend, brk_pend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps2_clk_m  <= 1'b0;
            ps2_clk_s  <= 1'b0;
            ps2_clk_d  <= 1'b0;
            ps2_data_m <= 1'b0;
            ps2_data_s <= 1'b0;
        end else begin
            ps2_clk_m  <= i_ps2_clk;
            ps2_clk_s  <= ps2_clk_m;
            ps2_clk_d  <= ps2_clk_s;
            ps2_data_m <= i_ps2_data;
            ps2_data_s <= ps2_data_m;
        end
    end

    assign fe = ps2_clk_d & ~ps2_clk_s;

    // All error sources are combinational so the prefix flags clear on the same edge as o_err
    assign start_err  = (state == ST_IDLE) && fe && ps2_data_s;
    assign stop_fe    = (state == ST_STOP) && fe;
    assign frame_good = stop_fe && ps2_data_s && (^{shift_q, parity_q});
    assign to_expire  = (state != ST_IDLE) && !fe && (to_cnt == TO_LAST);
    assign err_set    = start_err | to_expire | (stop_fe & ~frame_good);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            to_cnt   <= '0;
            rx_rdy   <= 1'b0;
            rx_byte  <= '0;
            o_err    <= 1'b0;
        end else begin
            rx_rdy <= frame_good;
            o_err  <= err_set;
            if (frame_good)
                rx_byte <= shift_q;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (fe && !ps2_data_s) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                default: begin
                    if (fe) begin
                        to_cnt <= '0;
                        case (state)
                            ST_DATA: begin
                                shift_q <= {ps2_data_s, shift_q[7:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7)
                                    state <= ST_PARITY;
                            end
                            ST_PARITY: begin
                                parity_q <= ps2_data_s;
                                state    <= ST_STOP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end else if (to_expire) begin
                        to_cnt <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            o_code      <= '0;
            o_extended  <= 1'b0;
            o_break     <= 1'b0;
            o_valid     <= 1'b0;
            o_key_left  <= 1'b0;
            o_key_right <= 1'b0;
            o_key_fire  <= 1'b0;
            o_key_start <= 1'b0;
            o_key_r     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (err_set) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (rx_rdy) begin
                if (rx_byte == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    o_valid    <= 1'b1;
                    o_code     <= rx_byte;
                    o_extended <= ext_pend;
                    o_break    <= brk_pend;
                    ext_pend   <= 1'b0;
                    brk_pend   <= 1'b0;
                    // Extended bit is part of the key identity (keypad 4 vs left arrow)
                    case ({ext_pend, rx_byte})
                        9'h16B:  o_key_left  <= ~brk_pend;
                        9'h174:  o_key_right <= ~brk_pend;
                        9'h029:  o_key_fire  <= ~brk_pend;
                        9'h05A:  o_key_start <= ~brk_pend;
                        9'h02D:  o_key_r     <= ~brk_pend;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the pins and
// checks decoded events, key flags, errors, latency and timeout timing.
module tb_ps2_key_decoder;

    localparam int T    = 2000;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] o_code;
    logic       o_extended, o_break, o_valid, o_err;
    logic       o_key_left, o_key_right, o_key_fire, o_key_start, o_key_r;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall = 0;
    int stop_fall = 0;

    logic [7:0] v_code  [16];
    logic       v_ext   [16];
    logic       v_brk   [16];
    logic [4:0] v_flags [16];
    int         v_cyc   [16];
    int         e_cyc   [16];
    int nv = 0;
    int ne = 0;
    int both = 0;

    ps2_key_decoder #(.TIMEOUT_CYC(T), .TO_W(11)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_code      (o_code),
        .o_extended  (o_extended),
        .o_break     (o_break),
        .o_valid     (o_valid),
        .o_err       (o_err),
        .o_key_left  (o_key_left),
        .o_key_right (o_key_right),
        .o_key_fire  (o_key_fire),
        .o_key_start (o_key_start),
        .o_key_r     (o_key_r)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling clock edge; flags = {left,right,fire,start,r}
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                if (nv < 16) begin
                    v_code[nv]  = o_code;
                    v_ext[nv]   = o_extended;
                    v_brk[nv]   = o_break;
                    v_flags[nv] = {o_key_left, o_key_right, o_key_fire, o_key_start, o_key_r};
                    v_cyc[nv]   = cyc;
                end
                nv = nv + 1;
            end
            if (o_err) begin
                if (ne < 16) e_cyc[ne] = cyc;
                ne = ne + 1;
            end
            if (o_valid && o_err) both = both + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        nv = 0;
        ne = 0;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_b, input int gap);
        logic p;
        p = (~^b) ^ par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stop_b);
        stop_fall = last_fall;
        ps2_data = 1'b1;
        tick(gap);
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        tick(3);
        outs = {o_code, o_extended, o_break, o_valid, o_err, o_key_left,
                o_key_right, o_key_fire, o_key_start, o_key_r};
        checks++;
        if (outs !== 18'h0) begin
            $display("FAIL reset_initial: outputs=%h want 0", outs); failures++;
        end
        rst = 1'b0;
        tick(5);
        clear_log();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        tick(1);
        outs = {o_code, o_extended, o_break, o_valid, o_err, o_key_left,
                o_key_right, o_key_fire, o_key_start, o_key_r};
        checks++;
        if (outs !== 18'h0) begin
            $display("FAIL reset_midframe: outputs=%h want 0", outs); failures++;
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        send_frame(8'h1C, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1) begin $display("FAIL reset_valid_count: got %0d want 1", nv); failures++; end
        checks++;
        if ({v_code[0], v_ext[0], v_brk[0]} !== {8'h1C, 1'b0, 1'b0}) begin
            $display("FAIL reset_event: code=%h ext=%b brk=%b want 1c 0 0", v_code[0], v_ext[0], v_brk[0]);
            failures++;
        end
        checks++;
        if (ne !== 0) begin $display("FAIL reset_err_count: got %0d want 0", ne); failures++; end
    endtask

    task automatic test_make_break_space();
        clear_log();
        checks++;
        if (o_key_fire !== 1'b0) begin $display("FAIL fire_initial: got %b want 0", o_key_fire); failures++; end
        send_frame(8'h29, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1 || v_flags[0][2] !== 1'b1 || v_brk[0] !== 1'b0) begin
            $display("FAIL fire_make: nv=%0d fire=%b brk=%b want 1 1 0", nv, v_flags[0][2], v_brk[0]);
            failures++;
        end
        send_frame(8'hF0, 1'b0, 1'b1, 20);
        send_frame(8'h29, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 2) begin $display("FAIL fire_valid_count: got %0d want 2", nv); failures++; end
        checks++;
        if ({v_code[1], v_ext[1], v_brk[1], v_flags[1][2]} !== {8'h29, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL fire_break: code=%h ext=%b brk=%b fire=%b want 29 0 1 0",
                     v_code[1], v_ext[1], v_brk[1], v_flags[1][2]);
            failures++;
        end
        checks++;
        if (o_key_fire !== 1'b0) begin $display("FAIL fire_final: got %b want 0", o_key_fire); failures++; end
    endtask

    task automatic test_extended();
        clear_log();
        send_frame(8'hE0, 1'b0, 1'b1, 20);
        send_frame(8'h6B, 1'b0, 1'b1, 20);
        send_frame(8'hE0, 1'b0, 1'b1, 20);
        send_frame(8'hF0, 1'b0, 1'b1, 20);
        send_frame(8'h6B, 1'b0, 1'b1, 20);
        send_frame(8'h6B, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 3 || ne !== 0) begin $display("FAIL ext_counts: nv=%0d ne=%0d want 3 0", nv, ne); failures++; end
        checks++;
        if ({v_code[0], v_ext[0], v_brk[0], v_flags[0][4]} !== {8'h6B, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL ext_make: code=%h ext=%b brk=%b left=%b want 6b 1 0 1",
                     v_code[0], v_ext[0], v_brk[0], v_flags[0][4]);
            failures++;
        end
        checks++;
        if ({v_code[1], v_ext[1], v_brk[1], v_flags[1][4]} !== {8'h6B, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL ext_break: code=%h ext=%b brk=%b left=%b want 6b 1 1 0",
                     v_code[1], v_ext[1], v_brk[1], v_flags[1][4]);
            failures++;
        end
        checks++;
        if ({v_code[2], v_ext[2], v_brk[2], v_flags[2][4]} !== {8'h6B, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL ext_keypad: code=%h ext=%b brk=%b left=%b want 6b 0 0 0",
                     v_code[2], v_ext[2], v_brk[2], v_flags[2][4]);
            failures++;
        end
    endtask

    task automatic test_parity_error();
        clear_log();
        send_frame(8'h2D, 1'b1, 1'b1, 20);
        checks++;
        if (ne !== 1 || nv !== 0 || o_key_r !== 1'b0) begin
            $display("FAIL parity_err: ne=%0d nv=%0d r=%b want 1 0 0", ne, nv, o_key_r); failures++;
        end
        clear_log();
        send_frame(8'h2D, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1 || ne !== 0 || o_key_r !== 1'b1) begin
            $display("FAIL parity_recover: nv=%0d ne=%0d r=%b want 1 0 1", nv, ne, o_key_r); failures++;
        end
    endtask

    task automatic test_timeout();
        clear_log();
        send_frame(8'hE0, 1'b0, 1'b1, 20);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        tick(T + 20);
        checks++;
        if (ne !== 1 || nv !== 0) begin $display("FAIL timeout_count: ne=%0d nv=%0d want 1 0", ne, nv); failures++; end
        checks++;
        if (e_cyc[0] - last_fall !== T + 3) begin
            $display("FAIL timeout_latency: got %0d want %0d", e_cyc[0] - last_fall, T + 3); failures++;
        end
        clear_log();
        send_frame(8'h74, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1 || v_code[0] !== 8'h74 || v_ext[0] !== 1'b0 || o_key_right !== 1'b0) begin
            $display("FAIL timeout_prefix: nv=%0d code=%h ext=%b right=%b want 1 74 0 0",
                     nv, v_code[0], v_ext[0], o_key_right);
            failures++;
        end
    endtask

    task automatic test_framing();
        clear_log();
        send_frame(8'h5A, 1'b0, 1'b0, 20);
        checks++;
        if (ne !== 1 || nv !== 0) begin $display("FAIL stop_err: ne=%0d nv=%0d want 1 0", ne, nv); failures++; end
        clear_log();
        send_bit(1'b1);
        tick(20);
        checks++;
        if (ne !== 1 || nv !== 0) begin $display("FAIL start_err: ne=%0d nv=%0d want 1 0", ne, nv); failures++; end
        clear_log();
        send_frame(8'h5A, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1 || ne !== 0) begin $display("FAIL good_width: nv=%0d ne=%0d want 1 0", nv, ne); failures++; end
        checks++;
        if (v_cyc[0] - stop_fall !== 4) begin
            $display("FAIL good_latency: got %0d want 4", v_cyc[0] - stop_fall); failures++;
        end
        checks++;
        if (o_code !== 8'h5A || o_valid !== 1'b0 || o_key_start !== 1'b1) begin
            $display("FAIL good_hold: code=%h valid=%b start=%b want 5a 0 1", o_code, o_valid, o_key_start);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 20);
        checks++;
        if (nv !== 1 || ne !== 0) begin $display("FAIL b2b_counts: nv=%0d ne=%0d want 1 0", nv, ne); failures++; end
        checks++;
        if ({v_code[0], v_brk[0], o_key_start} !== {8'h5A, 1'b1, 1'b0}) begin
            $display("FAIL b2b_event: code=%h brk=%b start=%b want 5a 1 0", v_code[0], v_brk[0], o_key_start);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_make_break_space();
        test_extended();
        test_parity_error();
        test_timeout();
        test_framing();
        test_back_to_back();
        checks++;
        if (both !== 0) begin $display("FAIL valid_err_overlap: got %0d want 0", both); failures++; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
